forward_ctrl: RTL and testbench
===============================

Name: forward_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage datapath.
- Tracks destination registers of instructions in EX and MEM and produces the 2-bit selects for the two 32-bit 3:1 ALU-operand muxes (00 = register file, 01 = EX/MEM result, 10 = MEM/WB result).
- Selects are registered so they are aligned with the instruction in EX.
- Asserts a stall on a load-use hazard and inserts a bubble.

Parameters:
- REG_W, 5, register-number width
- CNT_W, 16, width of the saturating stall counter

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous reset, active-high
- id_valid  input  1  a valid instruction is in ID this cycle
- id_rs  input  REG_W  source register A of the ID instruction
- id_rt  input  REG_W  source register B of the ID instruction
- id_uses_rt  input  1  ID instruction reads rt as an ALU operand
- id_rd  input  REG_W  destination register of the ID instruction
- id_regwrite  input  1  ID instruction writes the register file
- id_memread  input  1  ID instruction is a load
- flush  input  1  squash the ID instruction (branch taken)
- fwdA_sel  output  2  select for the operand-A mux, valid for the instruction in EX
- fwdB_sel  output  2  select for the operand-B mux, valid for the instruction in EX
- stall  output  1  combinational; hold PC and IF/ID, bubble into EX
- stall_count  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Internal state:
  - EX slot {ex_rd, ex_rw, ex_mr}: the instruction currently in EX.
  - MEM slot {mem_rd, mem_rw}: the instruction currently in MEM.
- Reset (async, Rst=1): all slot fields 0; fwdA_sel=fwdB_sel=2'b00; stall_count=0. stall therefore reads 0.
- Match definitions:
  - ex_hit(r) = ex_rw && ex_rd!=0 && ex_rd==r
  - mem_hit(r) = mem_rw && mem_rd!=0 && mem_rd==r
  - Register 0 never matches.
- stall (combinational) = id_valid && !flush && ex_mr && ex_rw && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- Each rising Clk edge, normal case (no stall, no flush, id_valid=1):
  - MEM slot <= EX slot.
  - EX slot <= {id_rd, id_regwrite, id_memread}.
  - fwdA_sel <= ex_hit(id_rs) ? 01 : mem_hit(id_rs) ? 10 : 00.
  - fwdB_sel: same rule using id_rt; forced to 00 when id_uses_rt=0.
  - Priority: when both slots hit, 01 (newest value) wins.
- Stall edge:
  - MEM slot <= EX slot.
  - EX slot <= bubble (all 0); fwdA_sel=fwdB_sel <= 00.
  - stall_count increments, saturating at all-ones.
  - Next cycle the load is in MEM; the held ID instruction re-evaluates and selects 10.
- Flush, or id_valid=0: MEM slot advances, EX slot <= bubble, selects <= 00, stall=0. flush has priority over stall.
- Selects never take the value 11.
- Reset asserted mid-operation clears all state immediately. The first edge after Rst deasserts behaves as normal from the cleared state.
- Write-back to the register file is write-before-read; no third forwarding level.
- Latency: select visible one cycle after the ID inputs; stall has zero latency.

Test Plan:
- Reset: Rst=1 mid-stream with slots loaded -> fwdA_sel=fwdB_sel=00, stall=0, stall_count=0 asynchronously, before the next edge.
- EX forward: cycle0 ID add rd=5 rw=1; cycle1 ID sub rs=5 rt=6 uses_rt=1 -> after edge2 fwdA_sel=01, fwdB_sel=00.
- MEM forward and priority:
  - Writer rd=7, then an unrelated instruction, then a reader rs=7 -> fwdA_sel=10.
  - Writers rd=7 back-to-back (two consecutive instructions), then reader rt=7 uses_rt=1 -> fwdB_sel=01.
- Load-use: lw rd=8 (mr=1, rw=1), next ID rs=8 -> stall=1 that cycle, selects 00 after the edge, stall_count=1. Next cycle with the held ID inputs, stall=0 and fwdA_sel=10 after the edge.
- Register 0 and uses_rt:
  - Writer rd=0 followed by reader rs=0 -> fwdA_sel=00.
  - Writer rd=9 followed by id_rt=9 with uses_rt=0 -> fwdB_sel=00.
  - lw rd=9 followed by id_rt=9 with uses_rt=0 -> stall=0.
- Flush and saturation:
  - flush=1 during a load-use condition -> stall=0 and EX slot bubbled.
  - With CNT_W=2 and 5 consecutive stalls -> stall_count holds at 3.

Source files
------------

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage datapath.
// Tracks the destination registers of the instructions in EX and MEM.
// Produces registered ALU-operand mux selects aligned with the EX instruction.
// Raises a zero-latency stall on a load-use hazard.
module forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // EX slot: the instruction currently in EX
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_rw_q, ex_rw_d;
    logic             ex_mr_q, ex_mr_d;
    // MEM slot: the instruction currently in MEM
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_rw_q, mem_rw_d;
    // Registered selects and the stall counter
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic             ex_writes;
    logic             mem_writes;
    logic             ex_hit_rs, ex_hit_rt;
    logic             mem_hit_rs, mem_hit_rt;
    logic             stall_c;
    logic             issue;
    logic [1:0]       sel_a, sel_b;

    // Hit detection against the older instructions; register 0 never matches
    always_comb begin
        ex_writes  = ex_rw_q && (ex_rd_q != '0);
        mem_writes = mem_rw_q && (mem_rd_q != '0);
        ex_hit_rs  = ex_writes && (ex_rd_q == id_rs);
        ex_hit_rt  = ex_writes && (ex_rd_q == id_rt);
        mem_hit_rs = mem_writes && (mem_rd_q == id_rs);
        mem_hit_rt = mem_writes && (mem_rd_q == id_rt);
        // A load in EX cannot forward yet: hold ID and bubble EX; flush wins
        stall_c = id_valid && !flush && ex_mr_q && ex_writes &&
                  ((ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt)));
        issue   = id_valid && !flush && !stall_c;
        // Newest producer (EX) wins over MEM when both hold the register
        sel_a = ex_hit_rs ? SEL_EX : (mem_hit_rs ? SEL_MEM : SEL_RF);
        if (!id_uses_rt) begin
            sel_b = SEL_RF;
        end else begin
            sel_b = ex_hit_rt ? SEL_EX : (mem_hit_rt ? SEL_MEM : SEL_RF);
        end
    end

    // Next-state: MEM always advances; EX takes ID or a bubble
    always_comb begin
        mem_rd_d      = ex_rd_q;
        mem_rw_d      = ex_rw_q;
        ex_rd_d       = '0;
        ex_rw_d       = 1'b0;
        ex_mr_d       = 1'b0;
        fwd_a_d       = SEL_RF;
        fwd_b_d       = SEL_RF;
        stall_count_d = stall_count_q;
        if (issue) begin
            ex_rd_d = id_rd;
            ex_rw_d = id_regwrite;
            ex_mr_d = id_memread;
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
        if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_rd_q       <= '0;
            ex_rw_q       <= 1'b0;
            ex_mr_q       <= 1'b0;
            mem_rd_q      <= '0;
            mem_rw_q      <= 1'b0;
            fwd_a_q       <= SEL_RF;
            fwd_b_q       <= SEL_RF;
            stall_count_q <= '0;
        end else begin
            ex_rd_q       <= ex_rd_d;
            ex_rw_q       <= ex_rw_d;
            ex_mr_q       <= ex_mr_d;
            mem_rd_q      <= mem_rd_d;
            mem_rw_q      <= mem_rw_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwdA_sel    = fwd_a_q;
    assign fwdB_sel    = fwd_b_q;
    assign stall       = stall_c;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed hazard scenarios plus randomized traffic,
// checked every cycle against an in-flight instruction model.
module tb_forward_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_uses_rt = 1'b0;
    logic [REG_W-1:0] id_rd = '0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       fwdA_sel;
    logic [1:0]       fwdB_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .fwdA_sel(fwdA_sel),
        .fwdB_sel(fwdB_sel), .stall(stall), .stall_count(stall_count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic seen_stall;
    bit verbose;

    // Model: instructions in flight, index 0 = EX (youngest), 1 = MEM
    typedef struct {
        int rd;
        bit writes;
        bit load;
    } instr_t;
    instr_t pipe [2];
    int m_sel_a, m_sel_b, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) pipe[i] = '{0, 0, 0};
        m_sel_a = 0;
        m_sel_b = 0;
        m_cnt = 0;
    endtask

    // Age of the youngest in-flight producer of r: 1 = EX, 2 = MEM, 0 = none
    function automatic int producer_age(input int r);
        for (int i = 0; i < 2; i++)
            if (r != 0 && pipe[i].writes && pipe[i].rd == r) return i + 1;
        return 0;
    endfunction

    // One clock of ID inputs: check at negedge, then step the model over the edge
    task automatic cyc(input bit v, input int rs, input int rt, input bit ut,
                       input int rd, input bit rw, input bit mr, input bit fl);
        bit exp_stall;
        bit issue;
        int na, nb;
        id_valid = v; id_rs = rs[REG_W-1:0]; id_rt = rt[REG_W-1:0];
        id_uses_rt = ut; id_rd = rd[REG_W-1:0]; id_regwrite = rw;
        id_memread = mr; flush = fl;
        @(negedge Clk);
        // Stall when the youngest producer of an operand is a load still in EX
        exp_stall = v && !fl && pipe[0].load &&
                    (producer_age(rs) == 1 || (ut && producer_age(rt) == 1));
        seen_stall = stall;
        chk("stall", int'(stall), int'(exp_stall));
        chk("fwdA_sel", int'(fwdA_sel), m_sel_a);
        chk("fwdB_sel", int'(fwdB_sel), m_sel_b);
        chk("stall_count", int'(stall_count), m_cnt);
        if (verbose)
            $display("txn v=%0d rs=%0d rt=%0d ut=%0d rd=%0d rw=%0d mr=%0d fl=%0d | stall=%0d A=%0d B=%0d cnt=%0d",
                     v, rs, rt, ut, rd, rw, mr, fl, stall, fwdA_sel, fwdB_sel, stall_count);
        issue = v && !fl && !exp_stall;
        na = issue ? producer_age(rs) : 0;
        nb = (issue && ut) ? producer_age(rt) : 0;
        @(posedge Clk);
        #1;
        pipe[1] = pipe[0];
        pipe[0] = issue ? instr_t'{rd, rw, mr} : instr_t'{0, 0, 0};
        m_sel_a = na;
        m_sel_b = nb;
        if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        verbose = 1;
        #12;
        chk("reset fwdA", int'(fwdA_sel), 0);
        chk("reset fwdB", int'(fwdB_sel), 0);
        chk("reset stall", int'(stall), 0);
        chk("reset count", int'(stall_count), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // EX forward
        cyc(1, 1, 2, 1, 5, 1, 0, 0);
        cyc(1, 5, 6, 1, 1, 1, 0, 0);
        chk("ex fwd A", int'(fwdA_sel), 1);
        chk("ex fwd B", int'(fwdB_sel), 0);
        nop(); nop();

        // MEM forward
        cyc(1, 0, 0, 0, 7, 1, 0, 0);
        cyc(1, 0, 0, 0, 3, 1, 0, 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 0);
        chk("mem fwd A", int'(fwdA_sel), 2);
        nop(); nop();

        // Both slots hit: newest wins
        cyc(1, 0, 0, 0, 7, 1, 0, 0);
        cyc(1, 0, 0, 0, 7, 1, 0, 0);
        cyc(1, 0, 7, 1, 0, 0, 0, 0);
        chk("priority B", int'(fwdB_sel), 1);
        nop(); nop();

        // Load-use
        cyc(1, 0, 0, 0, 8, 1, 1, 0);
        cyc(1, 8, 0, 0, 2, 1, 0, 0);
        chk("lu stall", int'(seen_stall), 1);
        chk("lu bubble A", int'(fwdA_sel), 0);
        chk("lu count", int'(stall_count), 1);
        cyc(1, 8, 0, 0, 2, 1, 0, 0);
        chk("lu replay stall", int'(seen_stall), 0);
        chk("lu replay A", int'(fwdA_sel), 2);
        nop(); nop();

        // Register 0 and uses_rt
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("r0 A", int'(fwdA_sel), 0);
        cyc(1, 0, 0, 0, 9, 1, 0, 0);
        cyc(1, 0, 9, 0, 0, 0, 0, 0);
        chk("no rt B", int'(fwdB_sel), 0);
        cyc(1, 0, 0, 0, 9, 1, 1, 0);
        cyc(1, 0, 9, 0, 0, 0, 0, 0);
        chk("no rt stall", int'(seen_stall), 0);
        nop(); nop();

        // Flush during load-use
        cyc(1, 0, 0, 0, 10, 1, 1, 0);
        cyc(1, 10, 0, 0, 11, 1, 0, 1);
        chk("flush stall", int'(seen_stall), 0);
        cyc(1, 10, 0, 0, 11, 1, 0, 0);
        chk("flush bubbled", int'(seen_stall), 0);
        chk("flush then A", int'(fwdA_sel), 2);

        // Asynchronous reset mid-stream
        cyc(1, 0, 0, 0, 4, 1, 0, 0);
        cyc(1, 4, 4, 1, 4, 1, 1, 0);
        chk("pre-reset A", int'(fwdA_sel), 1);
        id_valid = 1; id_rs = 4; id_uses_rt = 0;
        #1;
        chk("pre-reset stall", int'(stall), 1);
        #2;
        Rst = 1'b1;
        #1;
        chk("async fwdA", int'(fwdA_sel), 0);
        chk("async fwdB", int'(fwdB_sel), 0);
        chk("async stall", int'(stall), 0);
        chk("async count", int'(stall_count), 0);
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Saturating stall counter
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 0, 0, 0, 8, 1, 1, 0);
            cyc(1, 8, 0, 0, 1, 1, 0, 0);
            chk("sat count", int'(stall_count), (k < CNT_MAX) ? k : CNT_MAX);
            cyc(1, 8, 0, 0, 1, 1, 0, 0);
        end

        // Randomized traffic with small register numbers to provoke hits
        verbose = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
